udma_l2_port_mux: RTL
=====================

# udma_l2_port_mux

Merges the two L2 master ports of `pulp_io` into a single TCDM master port. The two ports are read-only (ro, index 0) and write-only (wo, index 1). The block sits directly downstream of `pulp_io` and directly upstream of the L2/TCDM interconnect, or `tcdm_model` in the bench. It arbitrates requests, holds a selected request stable until it is granted, and tracks outstanding transactions in order so each `rvalid`/`rdata` returns to the port that issued it.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width; byte enables are `DATA_WIDTH/8` wide.
- `MAX_OUTSTANDING`, default 4: depth of the ID FIFO. Must be a power of 2 and at least 2.

Ports. The block has one clock; reset is synchronous and active-high.
- `sys_clk_i`  in  1  clock.
- `sys_rst_i`  in  1  synchronous active-high reset.
- `in_req_i`  in  [1:0]  per-port request.
- `in_gnt_o`  out  [1:0]  per-port grant.
- `in_addr_i`  in  [1:0][ADDR_WIDTH]  per-port address.
- `in_wen_i`  in  [1:0]  per-port write-enable; active-low, 0 = write.
- `in_be_i`  in  [1:0][DATA_WIDTH/8]  per-port byte enables.
- `in_wdata_i`  in  [1:0][DATA_WIDTH]  per-port write data.
- `in_rvalid_o`  out  [1:0]  per-port response valid.
- `in_rdata_o`  out  [1:0][DATA_WIDTH]  per-port response data.
- `out_req_o`  out  1  merged request.
- `out_gnt_i`  in  1  merged grant.
- `out_addr_o`, `out_wen_o`, `out_be_o`, `out_wdata_o`  out  as above  fields of the selected port.
- `out_rvalid_i`  in  1  response valid.
- `out_rdata_i`  in  DATA_WIDTH  response data.
- `err_o`  out  1  sticky protocol error.

## Operation
**Arbitration**
- Eligible requests: `in_req_i`, masked to 0 while the ID FIFO is full.
- `out_req_o` = OR of the eligible requests.
- State `IDLE` (lock = 0): the winner is chosen combinationally (see Configuration).
- Transition to `LOCKED`: when `out_req_o`=1 and `out_gnt_i`=0, the winner is registered in `lock_id` and the block enters `LOCKED`.
- State `LOCKED`: the selection is forced to `lock_id` whatever the other port does.
- Transition to `IDLE`: on the handshake `out_req_o & out_gnt_i`.
- `out_*` fields are muxed from the selected port. When `out_req_o`=0 they carry the fields of port 0.
- `in_gnt_o[sel]` = `out_req_o & out_gnt_i`. The other port's grant is 0.

**ID FIFO**
- Every handshake pushes `sel` (1 bit).
- Every `out_rvalid_i` pops the head entry `h`.
- Occupancy counter is `$clog2(MAX_OUTSTANDING)+1` bits. Push and pop in the same cycle leave it unchanged.
- Full means count == `MAX_OUTSTANDING`. When full, `out_req_o` is forced to 0 even if a pop occurs in the same cycle; there is no pass-through.

**Response routing**
- `in_rvalid_o[h]` = `out_rvalid_i`. The other port's `in_rvalid_o` is 0.
- `in_rdata_o[h]` = `out_rdata_i`. The other port's `in_rdata_o` is 0.
- `out_rvalid_i` with an empty FIFO: no pop, both `in_rvalid_o` stay 0, and `err_o` sets and stays set until reset.

**Lock while full:** if the FIFO becomes full while in `LOCKED`, `out_req_o` drops and the lock is retained. The same port is presented when space frees.

## Timing
- Request path is combinational: `in_req_i` to `out_req_o`, and `out_gnt_i` to `in_gnt_o`. There is no added latency.
- Response path is combinational: `out_rvalid_i` plus the FIFO head to `in_rvalid_o`/`in_rdata_o`.
- Responses return in order, at least 1 cycle after their grant. The entry pushed in cycle N is poppable in cycle N+1.
- Reset values:
  - FIFO empty, count 0, `lock`=0, `lock_id`=0, RR pointer = port 0, `err_o`=0.
  - `out_req_o`=0, `in_gnt_o`=0, `in_rvalid_o`=0, `in_rdata_o`=0.
- Reset mid-transaction drops all outstanding IDs. Any `out_rvalid_i` after reset with an empty FIFO sets `err_o`.
- Ports must hold `req` and fields stable until granted; the block does not check this.

## Configuration
- Macro: `UDMA_L2_MUX_RR_EN`.
- Defined: round-robin arbitration. A 1-bit priority pointer points to the preferred port. On each handshake it moves to the port other than the one just granted. On a tie, the preferred port wins.
- Undefined: fixed priority, with port 0 (ro) always winning ties. There is no pointer register.
- Lock, FIFO and routing behaviour are identical in both builds.

## Test plan
- **Single read:** port 0 requests at addr 0x1C000000, `out_gnt_i`=1, response 0xDEADBEEF one cycle later → `in_gnt_o`=2'b01, then `in_rvalid_o`=2'b01 with `in_rdata_o[0]`=0xDEADBEEF. `err_o`=0.
- **Tie, RR build:** both ports request every cycle with a permanent grant → grants alternate 01,10,01,10. Without the macro, grants are 01 every cycle until port 0 drops.
- **Stall lock:** port 1 requests with `out_gnt_i`=0 for 3 cycles, and port 0 asserts on cycle 2 → `out_addr_o` stays port 1's address. Port 1 is granted first when `out_gnt_i` rises, then port 0.
- **Full FIFO:** `MAX_OUTSTANDING`=4, 4 grants issued, no responses → `out_req_o`=0 on cycle 5 despite `in_req_i`≠0. After one `out_rvalid_i`, `out_req_o` reasserts the next cycle.
- **Interleaved ordering:** grants in order 0,1,1,0 with 4 responses D0..D3 → routed to ports 0,1,1,0 in that order.
- **Spurious response:** `out_rvalid_i` with an empty FIFO → `in_rvalid_o`=0 and `err_o`=1, held until `sys_rst_i`, then 0.

Source files
------------

// File: rtl/udma_l2_port_mux.sv
// udma_l2_port_mux: merges the uDMA read-only (0) and write-only (1) L2 ports onto one TCDM master port.
// Define UDMA_L2_MUX_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module udma_l2_port_mux #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         sys_clk_i,
    input  logic                         sys_rst_i,
    input  logic [1:0]                   in_req_i,
    output logic [1:0]                   in_gnt_o,
    input  logic [1:0][ADDR_WIDTH-1:0]   in_addr_i,
    input  logic [1:0]                   in_wen_i,
    input  logic [1:0][DATA_WIDTH/8-1:0] in_be_i,
    input  logic [1:0][DATA_WIDTH-1:0]   in_wdata_i,
    output logic [1:0]                   in_rvalid_o,
    output logic [1:0][DATA_WIDTH-1:0]   in_rdata_o,
    output logic                         out_req_o,
    input  logic                         out_gnt_i,
    output logic [ADDR_WIDTH-1:0]        out_addr_o,
    output logic                         out_wen_o,
    output logic [DATA_WIDTH/8-1:0]      out_be_o,
    output logic [DATA_WIDTH-1:0]        out_wdata_o,
    input  logic                         out_rvalid_i,
    input  logic [DATA_WIDTH-1:0]        out_rdata_i,
    output logic                         err_o
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_lock_id;
    logic             r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic       w_full;
    logic       w_empty;
    logic [1:0] w_elig;
    logic       w_winner;
    logic       w_sel;
    logic       w_fsel;
    logic       w_hs;
    logic       w_pop;
    logic       w_head;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    // A full ID FIFO blocks new requests outright; a same-cycle pop does not bypass it.
    assign w_elig    = w_full ? 2'b00 : in_req_i;
    assign out_req_o = |w_elig;
    assign w_hs      = out_req_o & out_gnt_i;

`ifdef UDMA_L2_MUX_RR_EN
    logic r_prio;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_winner = 1'b0;
        if (w_elig == 2'b11) begin
            w_winner = r_prio;
        end else begin
            w_winner = w_elig[1];
        end
    end

    always_ff @(posedge sys_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (sys_rst_i) begin
            r_prio <= 1'b0;
        end else if (w_hs) begin
            r_prio <= ~w_sel;
        end
    end
`else
    assign w_winner = ~w_elig[0] & w_elig[1];
`endif

    assign w_sel  = (r_state == ST_LOCKED) ? r_lock_id : w_winner;
    assign w_fsel = out_req_o & w_sel;

    assign out_addr_o  = in_addr_i[w_fsel];
    assign out_wen_o   = in_wen_i[w_fsel];
    assign out_be_o    = in_be_i[w_fsel];
    assign out_wdata_o = in_wdata_i[w_fsel];

    always_comb begin
        in_gnt_o        = 2'b00;
        in_gnt_o[w_sel] = w_hs;
    end

    // The lock is kept while the FIFO is full so the stalled port is presented again first.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state   <= ST_IDLE;
            r_lock_id <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (out_req_o && !out_gnt_i) begin
                        r_state   <= ST_LOCKED;
                        r_lock_id <= w_winner;
                    end
                end
                ST_LOCKED: begin
                    if (w_hs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_pop  = out_rvalid_i & ~w_empty;
    assign w_head = r_fifo[r_rptr];

    // NOTE: the ID storage is not reset; occupancy gates every read, so stale entries are never used.
    always_ff @(posedge sys_clk_i) begin
        if (w_hs) begin
            r_fifo[r_wptr] <= w_sel;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_hs) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (out_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;

    always_comb begin
        in_rvalid_o = 2'b00;
        in_rdata_o  = '0;
        if (!w_empty) begin
            in_rvalid_o[w_head] = out_rvalid_i;
            in_rdata_o[w_head]  = out_rdata_i;
        end
    end

endmodule
